// File: rtl/gpu_pkg.sv
// Shared GPU core encodings: core pipeline stages and the per-thread LSU state.
package gpu_pkg;

    localparam logic [2:0] CS_IDLE    = 3'd0;
    localparam logic [2:0] CS_FETCH   = 3'd1;
    localparam logic [2:0] CS_DECODE  = 3'd2;
    localparam logic [2:0] CS_REQUEST = 3'd3;
    localparam logic [2:0] CS_WAIT    = 3'd4;
    localparam logic [2:0] CS_EXECUTE = 3'd5;
    localparam logic [2:0] CS_UPDATE  = 3'd6;
    localparam logic [2:0] CS_DONE    = 3'd7;

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        REQUESTING = 2'b01,
        WAITING    = 2'b10,
        DONE       = 2'b11
    } lsu_state_t;

endpackage

// File: rtl/thread_lsu.sv
// Per-thread load/store unit: turns decoded LDR/STR into one data-memory
// request/response handshake and keeps the last loaded word on lsu_out.
module thread_lsu
    import gpu_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [2:0]           core_state,
    input  logic                 mem_read_enable,
    input  logic                 mem_write_enable,
    input  logic [DATA_BITS-1:0] rs,
    input  logic [DATA_BITS-1:0] rt,
    output logic                 mem_read_valid,
    output logic [ADDR_BITS-1:0] mem_read_address,
    input  logic                 mem_read_ready,
    input  logic [DATA_BITS-1:0] mem_read_data,
    output logic                 mem_write_valid,
    output logic [ADDR_BITS-1:0] mem_write_address,
    output logic [DATA_BITS-1:0] mem_write_data,
    input  logic                 mem_write_ready,
    output logic [1:0]           lsu_state,
    output logic [DATA_BITS-1:0] lsu_out
);

    lsu_state_t state_q, state_d;
    logic is_load_q, is_load_d;

    logic                 rd_valid_q, rd_valid_d;
    logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
    logic                 wr_valid_q, wr_valid_d;
    logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_BITS-1:0] wr_data_q, wr_data_d;
    logic [DATA_BITS-1:0] lsu_out_q, lsu_out_d;

    logic [ADDR_BITS-1:0] rs_addr;
    logic                 is_request;

    // Size cast truncates or zero-extends the register operand to the address width.
    assign rs_addr    = ADDR_BITS'(rs);
    assign is_request = (core_state == CS_REQUEST);

    // State register; enable=0 freezes everything, including ready sampling.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            is_load_q <= 1'b0;
        end else if (enable) begin
            state_q   <= state_d;
            is_load_q <= is_load_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        is_load_d = is_load_q;
        case (state_q)
            IDLE: begin
                if (is_request && mem_read_enable) begin
                    state_d   = REQUESTING;
                    is_load_d = 1'b1;
                end else if (is_request && mem_write_enable) begin
                    state_d   = REQUESTING;
                    is_load_d = 1'b0;
                end
            end
            REQUESTING: state_d = WAITING;
            WAITING: begin
                if (is_load_q ? mem_read_ready : mem_write_ready)
                    state_d = DONE;
            end
            DONE: begin
                if (core_state == CS_UPDATE)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_valid_d = rd_valid_q;
        rd_addr_d  = rd_addr_q;
        wr_valid_d = wr_valid_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        lsu_out_d  = lsu_out_q;
        case (state_q)
            REQUESTING: begin
                if (is_load_q) begin
                    rd_valid_d = 1'b1;
                    rd_addr_d  = rs_addr;
                end else begin
                    wr_valid_d = 1'b1;
                    wr_addr_d  = rs_addr;
                    wr_data_d  = rt;
                end
            end
            WAITING: begin
                // Only the ready of the channel in flight is looked at.
                if (is_load_q && mem_read_ready) begin
                    rd_valid_d = 1'b0;
                    lsu_out_d  = mem_read_data;
                end else if (!is_load_q && mem_write_ready) begin
                    wr_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_addr_q  <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            lsu_out_q  <= '0;
        end else if (enable) begin
            rd_valid_q <= rd_valid_d;
            rd_addr_q  <= rd_addr_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            lsu_out_q  <= lsu_out_d;
        end
    end

    assign mem_read_valid    = rd_valid_q;
    assign mem_read_address  = rd_addr_q;
    assign mem_write_valid   = wr_valid_q;
    assign mem_write_address = wr_addr_q;
    assign mem_write_data    = wr_data_q;
    assign lsu_state         = state_q;
    assign lsu_out           = lsu_out_q;

endmodule

// File: tb/tb_thread_lsu.sv
// Bench for thread_lsu: table vectors, hand-written corner sequences and a
// randomized transaction stream checked against a transaction-level model.
module tb_thread_lsu;
    import gpu_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [2:0] core_state;
    logic       mem_read_enable, mem_write_enable;
    logic [7:0] rs, rt;
    logic       mem_read_valid, mem_read_ready;
    logic [7:0] mem_read_address, mem_read_data;
    logic       mem_write_valid, mem_write_ready;
    logic [7:0] mem_write_address, mem_write_data;
    logic [1:0] lsu_state;
    logic [7:0] lsu_out;

    int checks = 0;
    int errors = 0;
    logic [7:0] model_out;

    thread_lsu #(.ADDR_BITS(8), .DATA_BITS(8)) dut (
        .clk(clk), .reset(reset), .enable(enable), .core_state(core_state),
        .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
        .rs(rs), .rt(rt),
        .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
        .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
        .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
        .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
        .lsu_state(lsu_state), .lsu_out(lsu_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One complete access driven from IDLE; expectations are passed in.
    task automatic do_txn(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] d,
                          input logic [7:0] rdata, input int dly,
                          input bit exp_rd, input bit exp_wr, input logic [7:0] exp_out);
        core_state       = CS_REQUEST;
        mem_read_enable  = rd;
        mem_write_enable = wr;
        rs = a; rt = d;
        mem_read_data = rdata;
        // With zero delay the ready is already high before the request: it must be ignored until WAITING.
        mem_read_ready  = (dly == 0) && exp_rd;
        mem_write_ready = (dly == 0) && exp_wr;
        step();
        if (!(exp_rd || exp_wr)) begin
            chk("no_op_state", lsu_state, IDLE);
            core_state = CS_IDLE; mem_read_enable = 0; mem_write_enable = 0;
            chk("no_op_out", lsu_out, exp_out);
            return;
        end
        chk("req_state", lsu_state, REQUESTING);
        chk("req_no_valid", {mem_read_valid, mem_write_valid}, 2'b00);
        core_state = CS_WAIT;
        step();
        mem_read_enable = 0; mem_write_enable = 0;
        rs = ~a; rt = ~d;
        chk("wait_state", lsu_state, WAITING);
        for (int i = 0; i <= dly; i++) begin
            chk("rd_valid", mem_read_valid, exp_rd);
            chk("wr_valid", mem_write_valid, exp_wr);
            if (exp_rd) chk("rd_addr", mem_read_address, a);
            if (exp_wr) begin
                chk("wr_addr", mem_write_address, a);
                chk("wr_data", mem_write_data, d);
            end
            if (i == dly) break;
            // The idle channel's ready toggles freely; it must never complete the access.
            mem_read_ready  = exp_wr ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_write_ready = exp_rd ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
            chk("still_wait", lsu_state, WAITING);
        end
        mem_read_ready  = exp_rd;
        mem_write_ready = exp_wr;
        step();
        mem_read_ready = 0; mem_write_ready = 0;
        chk("done_state", lsu_state, DONE);
        chk("done_valids", {mem_read_valid, mem_write_valid}, 2'b00);
        chk("lsu_out", lsu_out, exp_out);
        core_state = CS_UPDATE;
        step();
        core_state = CS_IDLE;
        chk("update_idle", lsu_state, IDLE);
    endtask

    // Brings a load up to WAITING with valid high.
    task automatic start_load(input logic [7:0] a);
        core_state = CS_REQUEST; mem_read_enable = 1; rs = a;
        step();
        core_state = CS_WAIT; mem_read_enable = 0;
        step();
    endtask

    typedef struct {
        bit         rd, wr;
        logic [7:0] a, d, rdata;
        int         dly;
        bit         exp_rd, exp_wr;
        logic [7:0] exp_out;
    } vec_t;

    vec_t vecs[6];

    initial begin
        reset = 1; enable = 1; core_state = CS_IDLE;
        mem_read_enable = 0; mem_write_enable = 0; rs = 0; rt = 0;
        mem_read_ready = 0; mem_read_data = 0; mem_write_ready = 0;
        step(); step();
        chk("rst_state", lsu_state, IDLE);
        chk("rst_valids", {mem_read_valid, mem_write_valid}, 2'b00);
        chk("rst_addrs", {mem_read_address, mem_write_address, mem_write_data}, 24'h0);
        chk("rst_out", lsu_out, 8'h00);
        reset = 0;
        step();

        vecs[0] = '{0, 1, 8'h20, 8'h7F, 8'h99, 0, 0, 1, 8'h00};
        vecs[1] = '{1, 0, 8'h12, 8'h00, 8'hA5, 2, 1, 0, 8'hA5};
        vecs[2] = '{1, 1, 8'h05, 8'h66, 8'h3C, 1, 1, 0, 8'h3C};
        vecs[3] = '{0, 0, 8'h44, 8'h11, 8'hEE, 0, 0, 0, 8'h3C};
        vecs[4] = '{0, 1, 8'hFF, 8'h00, 8'h77, 3, 0, 1, 8'h3C};
        vecs[5] = '{1, 0, 8'h00, 8'hFF, 8'h00, 0, 1, 0, 8'h00};
        foreach (vecs[i])
            do_txn(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].rdata, vecs[i].dly,
                   vecs[i].exp_rd, vecs[i].exp_wr, vecs[i].exp_out);

        // Load abandoned by reset, then a late ready.
        mem_read_data = 8'h5A;
        do_txn(1, 0, 8'h31, 8'h00, 8'h5A, 0, 1, 0, 8'h5A);
        start_load(8'h40);
        chk("pre_rst_valid", mem_read_valid, 1'b1);
        reset = 1;
        step();
        reset = 0;
        chk("rst_mid_valid", mem_read_valid, 1'b0);
        chk("rst_mid_state", lsu_state, IDLE);
        chk("rst_mid_out", lsu_out, 8'h00);
        mem_read_ready = 1; mem_read_data = 8'hC3;
        step();
        mem_read_ready = 0;
        chk("late_ready_state", lsu_state, IDLE);
        chk("late_ready_out", lsu_out, 8'h00);

        // enable low in WAITING while ready pulses.
        start_load(8'h52);
        enable = 0; mem_read_data = 8'hB4;
        for (int i = 0; i < 5; i++) begin
            mem_read_ready = 1'(i % 2 == 0);
            step();
            chk("en_hold_state", lsu_state, WAITING);
            chk("en_hold_valid", mem_read_valid, 1'b1);
            chk("en_hold_addr", mem_read_address, 8'h52);
            chk("en_hold_out", lsu_out, 8'h00);
        end
        enable = 1; mem_read_ready = 1;
        step();
        mem_read_ready = 0;
        chk("en_resume_state", lsu_state, DONE);
        chk("en_resume_out", lsu_out, 8'hB4);

        // DONE ignores a fresh CS_REQUEST until CS_UPDATE.
        core_state = CS_REQUEST; mem_write_enable = 1; mem_read_enable = 1; rs = 8'h77;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("done_hold_state", lsu_state, DONE);
            chk("done_hold_valids", {mem_read_valid, mem_write_valid}, 2'b00);
        end
        mem_write_enable = 0; mem_read_enable = 0;
        core_state = CS_UPDATE;
        step();
        core_state = CS_IDLE;
        chk("done_release", lsu_state, IDLE);
        model_out = 8'hB4;

        // Randomized transactions against the transaction-level model.
        for (int n = 0; n < 40; n++) begin
            bit rd, wr;
            logic [7:0] a, d, rdata;
            int dly;
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            a = 8'($urandom); d = 8'($urandom); rdata = 8'($urandom);
            dly = $urandom_range(0, 4);
            if (rd) model_out = rdata;
            do_txn(rd, wr, a, d, rdata, dly, rd, wr && !rd, model_out);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
